atm_session_ctrl: RTL and testbench
===================================

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, number of wrong PIN entries before the card is retained (legal range 1..7).
REQ-002 Parameter HOLD_CYCLES, default 4, cycles that eject or retain is asserted (legal range 1..255).
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 card_in  in  1  level; card present in slot.
REQ-006 pin_valid  in  1  one-cycle pulse; PIN entry complete.
REQ-007 pin_ok  in  1  PIN compare result; qualified by pin_valid.
REQ-008 op_valid  in  1  one-cycle pulse; user selected a transaction.
REQ-009 op_done  in  1  one-cycle pulse; transaction datapath finished.
REQ-010 cancel  in  1  one-cycle pulse; user cancel key.
REQ-011 timeout  in  1  inactivity timer expiry, level.
REQ-012 tmr_start  out  1  timer enable, level.
REQ-013 tmr_restart  out  1  timer reload, one-cycle pulse.
REQ-014 eject  out  1  card eject command.
REQ-015 card_retain  out  1  card capture command.
REQ-016 session_active  out  1  high in PIN, MENU, TXN.
REQ-017 state  out  3  current state encoding.
REQ-018 attempts  out  3  wrong-PIN count of current session.

Function
REQ-019 States SHALL encode IDLE=0, PIN=1, MENU=2, TXN=3, EJECT=4, RETAIN=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-020 IDLE: card_in=1 -> PIN next cycle, attempts cleared to 0.
REQ-021 PIN: pin_valid&pin_ok -> MENU; pin_valid&!pin_ok -> attempts+1, and if new value equals MAX_TRIES -> RETAIN, else stay PIN.
REQ-022 MENU: op_valid -> TXN; TXN: op_done -> MENU.
REQ-023 PIN or MENU: cancel=1 or timeout=1 -> EJECT.
REQ-024 TXN: cancel, timeout, pin_valid, op_valid SHALL be ignored; only op_done or card removal leaves TXN.
REQ-025 Priority in one cycle: card_in=0 > cancel > timeout > pin_valid/op_valid/op_done.
REQ-026 card_in=0 in PIN, MENU or TXN -> IDLE next cycle, no eject/retain.
REQ-027 EJECT: eject=1 for exactly HOLD_CYCLES cycles, then eject=0 and wait for card_in=0, then IDLE.
REQ-028 RETAIN: card_retain=1 for exactly HOLD_CYCLES cycles, then IDLE regardless of card_in.
REQ-029 tmr_start SHALL equal 1 iff state is PIN or MENU (registered, same cycle as state).
REQ-030 tmr_restart SHALL pulse one cycle on the first cycle in PIN, the first cycle in MENU (including return from TXN), and the cycle after each wrong PIN that stays in PIN.
REQ-031 Hold counter SHALL be 8 bits, loaded on EJECT/RETAIN entry, no wrap.
REQ-032 All outputs SHALL be registered; no combinational input-to-output path.
REQ-033 attempts SHALL saturate at MAX_TRIES and hold its value until next IDLE->PIN transition.

Reset
REQ-034 rst=0 SHALL immediately force state=IDLE, attempts=0, hold counter=0, and all outputs 0.
REQ-035 Release of rst SHALL take effect at the next rising clk; reset mid-EJECT or mid-RETAIN SHALL abort the pulse.

Verification
REQ-036 card_in=1, pin_valid&pin_ok, op_valid, op_done -> states 0,1,2,3,2; tmr_restart pulses on PIN and both MENU entries.
REQ-037 Three wrong PINs (MAX_TRIES=3) -> attempts 1,2,3; RETAIN entered; card_retain high exactly 4 cycles; IDLE after.
REQ-038 In MENU assert timeout -> EJECT; eject high 4 cycles; state stays 4 until card_in=0, then 0.
REQ-039 Same cycle cancel=1 and pin_valid&pin_ok=1 in PIN -> EJECT, not MENU.
REQ-040 In TXN assert timeout and cancel -> state stays 3; op_done -> MENU with tmr_restart pulse.
REQ-041 rst=0 asynchronously during RETAIN cycle 2 -> card_retain=0 and state=0 before next clk edge.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ATM card-session controller: PIN entry, menu/transaction flow, timed card
// eject and capture. Every output is a registered copy of next-state decodes.
module atm_session_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_in,
  input  logic       pin_valid,
  input  logic       pin_ok,
  input  logic       op_valid,
  input  logic       op_done,
  input  logic       cancel,
  input  logic       timeout,
  output logic       tmr_start,
  output logic       tmr_restart,
  output logic       eject,
  output logic       card_retain,
  output logic       session_active,
  output logic [2:0] state,
  output logic [2:0] attempts
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_TXN    = 3'd3,
    S_EJECT  = 3'd4,
    S_RETAIN = 3'd5
  } state_t;

  localparam logic [2:0] LP_MAX  = 3'(MAX_TRIES);
  localparam logic [7:0] LP_HOLD = 8'(HOLD_CYCLES);

  state_t     r_state;
  state_t     w_nxt;
  logic [7:0] r_hold;
  logic [2:0] r_attempts;
  logic [2:0] w_new_att;
  logic       w_wrong_pin;
  logic       w_hold_entry;
  logic       r_tmr_start;
  logic       r_tmr_restart;
  logic       r_eject;
  logic       r_card_retain;
  logic       r_session_active;

  // Card removal outranks cancel, which outranks timeout, which outranks user pulses.
  always_comb begin
    w_nxt       = r_state;
    w_wrong_pin = 1'b0;
    w_new_att   = r_attempts;
    case (r_state)
      S_IDLE: begin
        if (card_in) w_nxt = S_PIN;
      end
      S_PIN: begin
        if (!card_in)               w_nxt = S_IDLE;
        else if (cancel || timeout) w_nxt = S_EJECT;
        else if (pin_valid) begin
          if (pin_ok) w_nxt = S_MENU;
          else begin
            w_wrong_pin = 1'b1;
            w_new_att   = (r_attempts >= LP_MAX) ? LP_MAX : r_attempts + 3'd1;
            w_nxt       = (w_new_att == LP_MAX) ? S_RETAIN : S_PIN;
          end
        end
      end
      S_MENU: begin
        if (!card_in)               w_nxt = S_IDLE;
        else if (cancel || timeout) w_nxt = S_EJECT;
        else if (op_valid)          w_nxt = S_TXN;
      end
      S_TXN: begin
        if (!card_in)     w_nxt = S_IDLE;
        else if (op_done) w_nxt = S_MENU;
      end
      S_EJECT: begin
        if (r_hold == 8'd0 && !card_in) w_nxt = S_IDLE;
      end
      S_RETAIN: begin
        if (r_hold <= 8'd1) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_hold_entry = (w_nxt != r_state) && (w_nxt == S_EJECT || w_nxt == S_RETAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_attempts       <= 3'd0;
      r_hold           <= 8'd0;
      r_tmr_start      <= 1'b0;
      r_tmr_restart    <= 1'b0;
      r_eject          <= 1'b0;
      r_card_retain    <= 1'b0;
      r_session_active <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && w_nxt == S_PIN) r_attempts <= 3'd0;
      else                                     r_attempts <= w_new_att;
      // Hold counter counts HOLD_CYCLES down to zero and parks there.
      if (w_hold_entry)         r_hold <= LP_HOLD;
      else if (r_hold != 8'd0)  r_hold <= r_hold - 8'd1;
      r_eject          <= (w_nxt == S_EJECT)  && (w_hold_entry || r_hold > 8'd1);
      r_card_retain    <= (w_nxt == S_RETAIN) && (w_hold_entry || r_hold > 8'd1);
      r_tmr_start      <= (w_nxt == S_PIN) || (w_nxt == S_MENU);
      r_session_active <= (w_nxt == S_PIN) || (w_nxt == S_MENU) || (w_nxt == S_TXN);
      r_tmr_restart    <= ((w_nxt == S_PIN)  && (r_state != S_PIN || w_wrong_pin)) ||
                          ((w_nxt == S_MENU) && (r_state != S_MENU));
    end
  end

  assign state          = r_state;
  assign attempts       = r_attempts;
  assign tmr_start      = r_tmr_start;
  assign tmr_restart    = r_tmr_restart;
  assign eject          = r_eject;
  assign card_retain    = r_card_retain;
  assign session_active = r_session_active;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed vector table, async-reset sequence,
// then randomized traffic against a session-level reference model.
module tb_atm_session_ctrl;

  localparam int MT = 3;
  localparam int H  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       card_in = 1'b0, pin_valid = 1'b0, pin_ok = 1'b0;
  logic       op_valid = 1'b0, op_done = 1'b0, cancel = 1'b0, timeout = 1'b0;
  logic       tmr_start, tmr_restart, eject, card_retain, session_active;
  logic [2:0] state, attempts;

  int n_checks = 0;
  int n_fail   = 0;

  atm_session_ctrl #(.MAX_TRIES(MT), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .pin_valid(pin_valid), .pin_ok(pin_ok),
    .op_valid(op_valid), .op_done(op_done), .cancel(cancel), .timeout(timeout),
    .tmr_start(tmr_start), .tmr_restart(tmr_restart), .eject(eject),
    .card_retain(card_retain), .session_active(session_active),
    .state(state), .attempts(attempts)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit c, pv, ok, ov, od, cn, to;
    int st;
    bit rs, ej, rt;
    int att;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit c, bit pv, bit ok, bit ov, bit od, bit cn, bit to,
                             int st, bit rs, bit ej, bit rt, int att);
    vec_t r;
    r.c = c; r.pv = pv; r.ok = ok; r.ov = ov; r.od = od; r.cn = cn; r.to = to;
    r.st = st; r.rs = rs; r.ej = ej; r.rt = rt; r.att = att;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c, input bit pv, input bit ok, input bit ov,
                       input bit od, input bit cn, input bit to);
    card_in = c; pin_valid = pv; pin_ok = ok; op_valid = ov;
    op_done = od; cancel = cn; timeout = to;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state_derived(input string tag, input int st);
    chk({tag, ".tmr_start"}, tmr_start, (st == 1 || st == 2) ? 1 : 0);
    chk({tag, ".session_active"}, session_active, (st >= 1 && st <= 3) ? 1 : 0);
  endtask

  // Reference model: session phase with spec codes, wrong-PIN tally, age in phase.
  int ms, matt, mage;

  initial begin
    // Directed table: normal flow, retain, cancel-vs-PIN, TXN masking, card pull.
    vecs.push_back(v(1,0,0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,0,0,0,0));
    vecs.push_back(v(1,1,1,0,0,0,0, 2,1,0,0,0));
    vecs.push_back(v(1,0,0,1,0,0,0, 3,0,0,0,0));
    vecs.push_back(v(1,0,0,0,1,0,0, 2,1,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,0, 4,0,1,0,0));
    for (int i = 0; i < H-1; i++) vecs.push_back(v(1,0,0,0,0,0,0, 4,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 4,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(v(1,1,0,0,0,0,0, 1,1,0,0,1));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,0,0,0,1));
    vecs.push_back(v(1,1,0,0,0,0,0, 1,1,0,0,2));
    vecs.push_back(v(1,1,0,0,0,0,0, 5,0,0,1,3));
    for (int i = 0; i < H-1; i++) vecs.push_back(v(1,0,0,0,0,0,0, 5,0,0,1,3));
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,3));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(v(1,1,1,0,0,1,0, 4,0,1,0,0));
    for (int i = 0; i < H-2; i++) vecs.push_back(v(1,0,0,0,0,0,0, 4,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 4,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 4,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(v(1,1,1,0,0,0,0, 2,1,0,0,0));
    vecs.push_back(v(1,0,0,1,0,0,0, 3,0,0,0,0));
    vecs.push_back(v(1,1,1,1,0,1,1, 3,0,0,0,0));
    vecs.push_back(v(1,0,0,0,1,0,0, 2,1,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,1, 4,0,1,0,0));
    for (int i = 0; i < H-1; i++) vecs.push_back(v(1,0,0,0,0,0,1, 4,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 4,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 4,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(v(0,1,1,0,0,1,0, 0,0,0,0,0));

    // Reset state
    #3;
    chk("reset.state", state, 0);
    chk("reset.attempts", attempts, 0);
    chk("reset.outputs", {tmr_start, tmr_restart, eject, card_retain, session_active}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle.state", state, 0);

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      drive(vecs[k].c, vecs[k].pv, vecs[k].ok, vecs[k].ov, vecs[k].od, vecs[k].cn, vecs[k].to);
      step();
      chk({tag, ".state"}, state, vecs[k].st);
      chk({tag, ".tmr_restart"}, tmr_restart, vecs[k].rs);
      chk({tag, ".eject"}, eject, vecs[k].ej);
      chk({tag, ".card_retain"}, card_retain, vecs[k].rt);
      chk({tag, ".attempts"}, attempts, vecs[k].att);
      chk_state_derived(tag, vecs[k].st);
    end

    // Asynchronous reset in the second RETAIN cycle aborts the capture pulse.
    drive(1,0,0,0,0,0,0); step();
    chk("ar.pin", state, 1);
    for (int i = 0; i < MT; i++) begin
      drive(1,1,0,0,0,0,0); step();
    end
    drive(1,0,0,0,0,0,0);
    chk("ar.retain_entry", state, 5);
    step();
    chk("ar.retain_c2", card_retain, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar.state", state, 0);
    chk("ar.card_retain", card_retain, 0);
    chk("ar.attempts", attempts, 0);
    chk("ar.outputs", {tmr_start, tmr_restart, eject, session_active}, 0);
    drive(0,0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar.post_idle", state, 0);

    // Randomized traffic against the reference model.
    ms = 0; matt = 0; mage = 0;
    for (int n = 0; n < 3000; n++) begin
      bit c, pv, ok, ov, od, cn, to, wp;
      int old;
      c  = ($urandom_range(0, 19) != 0);
      pv = ($urandom_range(0, 3) == 0);
      ok = ($urandom_range(0, 2) == 0);
      ov = ($urandom_range(0, 3) == 0);
      od = ($urandom_range(0, 3) == 0);
      cn = ($urandom_range(0, 15) == 0);
      to = ($urandom_range(0, 15) == 0);
      drive(c, pv, ok, ov, od, cn, to);
      old = ms; wp = 0;
      case (ms)
        0: if (c) begin ms = 1; matt = 0; end
        1: if (!c) ms = 0;
           else if (cn || to) ms = 4;
           else if (pv && ok) ms = 2;
           else if (pv) begin
             matt = (matt + 1 > MT) ? MT : matt + 1;
             wp = 1;
             if (matt == MT) ms = 5;
           end
        2: if (!c) ms = 0; else if (cn || to) ms = 4; else if (ov) ms = 3;
        3: if (!c) ms = 0; else if (od) ms = 2;
        4: if (mage >= H && !c) ms = 0;
        5: if (mage == H - 1) ms = 0;
        default: ms = 0;
      endcase
      mage = (ms == old) ? mage + 1 : 0;
      step();
      chk("rnd.state", state, ms);
      chk("rnd.attempts", attempts, matt);
      chk("rnd.eject", eject, (ms == 4 && mage < H) ? 1 : 0);
      chk("rnd.card_retain", card_retain, (ms == 5) ? 1 : 0);
      chk("rnd.tmr_restart", tmr_restart,
          ((ms == 1 && (old != 1 || wp)) || (ms == 2 && old != 2)) ? 1 : 0);
      chk_state_derived("rnd", ms);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
